accumulator_multichannel: RTL and testbench
===========================================

# accumulator_multichannel

Signed binary accumulator bank holding CHANNEL_COUNT independent accumulators behind one shared, pipelined adder. Operations (increment, load, clear, read) arrive on a valid/ready command port tagged with a channel number; each accepted command produces exactly one result pulse after a fixed latency. A same-channel hazard interlock lets back-to-back commands to different channels stream at one per cycle, and same-channel read-after-write stays correct at any pipeline depth. Used for per-stream counters and statistics, and for digit-per-channel counters in unusual bases.

## Interface
- WORD_WIDTH, 16: width of each accumulator, op_value, and result_value.
- CHANNEL_COUNT, 4: number of accumulators (≥1).
- EXTRA_PIPE_STAGES, 1: pipeline registers between command acceptance and the adder (≥0).
- INITIAL_VALUE, 0: value of every channel after reset, clear, or clear_all.
- CHANNEL_ADDR_WIDTH (localparam): max(1, clog2(CHANNEL_COUNT)).
- clock  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_all  in  1  synchronous level; reinitialises all channels and flushes the pipeline.
- op_valid  in  1  command present.
- op_ready  out  1  command accepted at the edge where op_valid && op_ready.
- op_code  in  2  00 increment, 01 load, 10 clear channel, 11 read.
- op_channel  in  CHANNEL_ADDR_WIDTH  target channel; values ≥ CHANNEL_COUNT are treated as a read of channel 0.
- op_value  in  WORD_WIDTH  signed increment or load value; ignored for clear and read.
- result_valid  out  1  one-cycle pulse per retired command; no backpressure.
- result_channel  out  CHANNEL_ADDR_WIDTH  channel of the retired command.
- result_value  out  WORD_WIDTH  channel value after the command.
- result_overflow  out  1  the channel's overflow flag after the command.

## Operation
- The command, the channel's current value, and the channel's overflow flag are all captured at acceptance and travel through EXTRA_PIPE_STAGES registers. The add and write-back happen in the final stage.
- Increment: new = old + op_value (signed). Overflow is set when the operands have equal sign and the sum's sign differs from theirs; otherwise overflow is cleared.
- Load: new = op_value, overflow = 0.
- Clear: new = INITIAL_VALUE, overflow = 0.
- Read: value and overflow are unchanged; the current values are reported on the result port.
- Hazard interlock: op_ready = 0 while any valid pipeline stage holds op_channel. The interlock applies to reads as well. op_ready is combinational from op_channel and pipeline state; op_valid must not depend on op_ready.
- With EXTRA_PIPE_STAGES = 0, the value is read and written in the same cycle and there is no interlock.
- clear_all: discards all in-flight commands (they produce no result_valid) and sets every channel to INITIAL_VALUE and every overflow flag to 0. op_ready = 0 while clear_all is high. clear_all overrides a simultaneous acceptance.
- Reset: all channels = INITIAL_VALUE, overflow flags = 0, pipeline valids = 0, result_* = 0, op_ready = 0 while reset is asserted.

## Timing
- Latency: L = EXTRA_PIPE_STAGES + 1. A command accepted at edge n yields result_valid high during the cycle after edge n+L.
- Throughput: one command per cycle when consecutive commands target different channels.
- Same channel back-to-back: the second command is accepted no earlier than L cycles after the first.
- Results appear in acceptance order.
- The stored channel value updates at the same edge that raises result_valid.
- Reset deassertion: op_ready rises in the first cycle after reset falls, provided clear_all = 0.
- Reset asserted mid-operation: immediate clear of all state; in-flight commands are lost and produce no result.

## Configuration
- ACCUMULATOR_MULTICHANNEL_SATURATE_EN defined: on signed overflow the increment clamps to the most positive value (positive overflow) or the most negative value (negative overflow), and overflow = 1.
- Not defined: the sum wraps modulo 2^WORD_WIDTH, and overflow = 1.
- Overflow detection and all other behaviour are identical in both builds.

## Test plan
All scenarios use WORD_WIDTH=8, CHANNEL_COUNT=4, EXTRA_PIPE_STAGES=2, INITIAL_VALUE=0.
- Reset, then read channels 0–3 -> four result pulses with value 0x00 and overflow 0, 3 cycles after each accept.
- Increment ch1 by 0x05 three times, op_valid held high -> each accept is followed by 2 cycles of op_ready=0; results 0x05, 0x0A, 0x0F.
- Load ch2 0x7F, then increment ch2 0x01 -> results 0x7F/0, then 0x80/1 (wrap build) or 0x7F/1 (saturate build); a following load of 0x00 gives 0x00/0.
- Increments of 0x01 to ch0, ch1, ch2, ch3 on consecutive cycles -> no stall; four results on consecutive cycles, in order, channels 0–3, each value 0x01.
- Two commands in flight, then clear_all pulsed for 1 cycle -> no result_valid for either command; a subsequent read of any channel returns 0x00/0.
- reset asserted asynchronously between clock edges while commands are in flight -> outputs go to 0 immediately, no result pulses follow, and all channels read back 0x00.

Source files
------------

// File: rtl/accumulator_multichannel.sv
// Multichannel signed accumulator bank sharing one pipelined adder, with a same-channel hazard interlock.
// Build option: define ACCUMULATOR_MULTICHANNEL_SATURATE_EN to clamp on overflow instead of wrapping.
module accumulator_multichannel #(
  parameter int WORD_WIDTH        = 16,
  parameter int CHANNEL_COUNT     = 4,
  parameter int EXTRA_PIPE_STAGES = 1,
  parameter logic [WORD_WIDTH-1:0] INITIAL_VALUE = '0,
  localparam int CHANNEL_ADDR_WIDTH = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          clear_all_i,
  input  logic                          op_valid_i,
  output logic                          op_ready_o,
  input  logic [1:0]                    op_code_i,
  input  logic [CHANNEL_ADDR_WIDTH-1:0] op_channel_i,
  input  logic [WORD_WIDTH-1:0]         op_value_i,
  output logic                          result_valid_o,
  output logic [CHANNEL_ADDR_WIDTH-1:0] result_channel_o,
  output logic [WORD_WIDTH-1:0]         result_value_o,
  output logic                          result_overflow_o
);

  localparam int P  = EXTRA_PIPE_STAGES;
  localparam int W  = WORD_WIDTH;
  localparam int CW = CHANNEL_ADDR_WIDTH;

  typedef enum logic [1:0] {OP_INC = 2'b00, OP_LOAD = 2'b01, OP_CLEAR = 2'b10, OP_READ = 2'b11} op_e;

  logic [W-1:0]             acc_q [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] ovf_q;

  // Stage P is the final stage: its operands feed the adder and write back at the next edge.
  logic [P:0]  stg_valid_q;
  op_e         stg_code_q    [P+1];
  logic [CW-1:0] stg_ch_q    [P+1];
  logic [W-1:0]  stg_val_q   [P+1];
  logic [W-1:0]  stg_old_q   [P+1];
  logic [P:0]    stg_oldovf_q;

  logic          result_valid_q, result_ovf_q;
  logic [CW-1:0] result_ch_q;
  logic [W-1:0]  result_val_q;

  logic          in_range, hazard, accept, fwd, sum_ovf, new_ovf, cap_ovf;
  logic [CW-1:0] eff_ch;
  op_e           eff_code;
  logic [W-1:0]  fin_old, fin_opv, sum_w, new_val, cap_old;

  assign in_range = (int'(op_channel_i) < CHANNEL_COUNT);
  assign eff_ch   = in_range ? op_channel_i : '0;
  assign eff_code = in_range ? op_e'(op_code_i) : OP_READ;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < P; i++) begin
      if (stg_valid_q[i] && (stg_ch_q[i] == eff_ch)) hazard = 1'b1;
    end
  end

  assign op_ready_o = !reset_i && !clear_all_i && !hazard;
  assign accept     = op_valid_i && op_ready_o;

  assign fin_old = stg_old_q[P];
  assign fin_opv = stg_val_q[P];
  assign sum_w   = fin_old + fin_opv;
  assign sum_ovf = (fin_old[W-1] == fin_opv[W-1]) && (sum_w[W-1] != fin_old[W-1]);

  always_comb begin
    new_val = fin_old;
    new_ovf = stg_oldovf_q[P];
    case (stg_code_q[P])
      OP_INC: begin
        new_val = sum_w;
        new_ovf = sum_ovf;
`ifdef ACCUMULATOR_MULTICHANNEL_SATURATE_EN
        if (sum_ovf) new_val = fin_old[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      end
      OP_LOAD: begin
        new_val = fin_opv;
        new_ovf = 1'b0;
      end
      OP_CLEAR: begin
        new_val = INITIAL_VALUE;
        new_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  // A command captured at the same edge the final stage writes its channel must see the new value.
  assign fwd     = stg_valid_q[P] && (stg_ch_q[P] == eff_ch);
  assign cap_old = fwd ? new_val : acc_q[eff_ch];
  assign cap_ovf = fwd ? new_ovf : ovf_q[eff_ch];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) acc_q[c] <= INITIAL_VALUE;
      ovf_q        <= '0;
      stg_valid_q  <= '0;
      stg_oldovf_q <= '0;
      for (int i = 0; i <= P; i++) begin
        stg_code_q[i] <= OP_INC;
        stg_ch_q[i]   <= '0;
        stg_val_q[i]  <= '0;
        stg_old_q[i]  <= '0;
      end
      result_valid_q <= 1'b0;
      result_ch_q    <= '0;
      result_val_q   <= '0;
      result_ovf_q   <= 1'b0;
    end else if (clear_all_i) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) acc_q[c] <= INITIAL_VALUE;
      ovf_q          <= '0;
      stg_valid_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      stg_valid_q[0]  <= accept;
      stg_code_q[0]   <= eff_code;
      stg_ch_q[0]     <= eff_ch;
      stg_val_q[0]    <= op_value_i;
      stg_old_q[0]    <= cap_old;
      stg_oldovf_q[0] <= cap_ovf;
      for (int i = 1; i <= P; i++) begin
        stg_valid_q[i]  <= stg_valid_q[i-1];
        stg_code_q[i]   <= stg_code_q[i-1];
        stg_ch_q[i]     <= stg_ch_q[i-1];
        stg_val_q[i]    <= stg_val_q[i-1];
        stg_old_q[i]    <= stg_old_q[i-1];
        stg_oldovf_q[i] <= stg_oldovf_q[i-1];
      end
      result_valid_q <= stg_valid_q[P];
      if (stg_valid_q[P]) begin
        acc_q[stg_ch_q[P]] <= new_val;
        ovf_q[stg_ch_q[P]] <= new_ovf;
        result_ch_q        <= stg_ch_q[P];
        result_val_q       <= new_val;
        result_ovf_q       <= new_ovf;
      end
    end
  end

  assign result_valid_o    = result_valid_q;
  assign result_channel_o  = result_ch_q;
  assign result_value_o    = result_val_q;
  assign result_overflow_o = result_ovf_q;

endmodule

// File: tb/tb_accumulator_multichannel.sv
// Scoreboard bench for accumulator_multichannel (8-bit words, 4 channels, 2 extra pipe stages).
module tb_accumulator_multichannel;

  localparam int W = 8;
  localparam int C = 4;
  localparam int P = 2;
  localparam int LAT = P + 1;

`ifdef ACCUMULATOR_MULTICHANNEL_SATURATE_EN
  localparam logic [7:0] OVF_VAL = 8'h7F;
`else
  localparam logic [7:0] OVF_VAL = 8'h80;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_all = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] op_code = 2'b00;
  logic [1:0] op_channel = 2'b00;
  logic [7:0] op_value = 8'h00;
  logic       result_valid;
  logic [1:0] result_channel;
  logic [7:0] result_value;
  logic       result_overflow;

  accumulator_multichannel #(
    .WORD_WIDTH(W), .CHANNEL_COUNT(C), .EXTRA_PIPE_STAGES(P), .INITIAL_VALUE(8'h00)
  ) dut (
    .clock_i(clk), .reset_i(rst), .clear_all_i(clear_all),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_code_i(op_code),
    .op_channel_i(op_channel), .op_value_i(op_value),
    .result_valid_o(result_valid), .result_channel_o(result_channel),
    .result_value_o(result_value), .result_overflow_o(result_overflow)
  );

  typedef struct {
    logic [1:0] ch;
    logic [7:0] val;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int st;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance with op_valid still high.
  task automatic send(input logic [1:0] code, input logic [1:0] ch, input logic [7:0] val,
                      input bit push, input logic [7:0] ev, input logic eo, output int stalls);
    exp_t e;
    op_valid = 1'b1;
    op_code = code;
    op_channel = ch;
    op_value = val;
    stalls = 0;
    #1;
    while (!op_ready && stalls < 16) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!op_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: ch=%0d never accepted, required acceptance within 16 cycles", ch);
    end else begin
      if (push) begin
        e.ch = ch; e.val = ev; e.ovf = eo; e.acc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got ch=%0d val=0x%0h, required no result", result_channel, result_value);
      end else begin
        e = sb.pop_front();
        check("result_ch_val_ovf", 32'({result_channel, result_value, result_overflow}),
              32'({e.ch, e.val, e.ovf}));
        check("result_latency", 32'(cyc - e.acc), 32'(LAT));
      end
    end
  end

  initial begin
    #12;
    check("reset_ready", 32'(op_ready), 32'd0);
    check("reset_rvalid", 32'(result_valid), 32'd0);
    check("reset_rvalue", 32'(result_value), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(op_ready), 32'd1);
    @(negedge clk);

    for (int ch = 0; ch < C; ch++) send(2'b11, 2'(ch), 8'h00, 1'b1, 8'h00, 1'b0, st);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);

    send(2'b00, 2'd1, 8'h05, 1'b1, 8'h05, 1'b0, st);
    send(2'b00, 2'd1, 8'h05, 1'b1, 8'h0A, 1'b0, st);
    check("same_ch_stall_2", 32'(st), 32'd2);
    send(2'b00, 2'd1, 8'h05, 1'b1, 8'h0F, 1'b0, st);
    check("same_ch_stall_3", 32'(st), 32'd2);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);

    send(2'b01, 2'd2, 8'h7F, 1'b1, 8'h7F, 1'b0, st);
    send(2'b00, 2'd2, 8'h01, 1'b1, OVF_VAL, 1'b1, st);
    send(2'b01, 2'd2, 8'h00, 1'b1, 8'h00, 1'b0, st);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);

    send(2'b00, 2'd0, 8'h03, 1'b0, 8'h00, 1'b0, st);
    send(2'b00, 2'd3, 8'h04, 1'b0, 8'h00, 1'b0, st);
    op_valid = 1'b0;
    clear_all = 1'b1;
    #1;
    check("ready_during_clear_all", 32'(op_ready), 32'd0);
    @(negedge clk);
    clear_all = 1'b0;
    repeat (5) @(negedge clk);
    send(2'b11, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, st);
    send(2'b11, 2'd3, 8'h00, 1'b1, 8'h00, 1'b0, st);
    send(2'b11, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, st);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);

    for (int ch = 0; ch < C; ch++) begin
      send(2'b00, 2'(ch), 8'h01, 1'b1, 8'h01, 1'b0, st);
      check("stream_no_stall", 32'(st), 32'd0);
    end
    send(2'b10, 2'd1, 8'h55, 1'b1, 8'h00, 1'b0, st);
    send(2'b11, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, st);
    send(2'b11, 2'd3, 8'h00, 1'b1, 8'h01, 1'b0, st);
    op_valid = 1'b0;
    repeat (6) @(negedge clk);

    send(2'b11, 2'd2, 8'h00, 1'b1, 8'h01, 1'b0, st);
    send(2'b00, 2'd0, 8'h02, 1'b0, 8'h00, 1'b0, st);
    send(2'b00, 2'd1, 8'h03, 1'b0, 8'h00, 1'b0, st);
    op_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rvalid", 32'(result_valid), 32'd0);
    check("async_rst_rvalue", 32'(result_value), 32'd0);
    check("async_rst_rchannel", 32'(result_channel), 32'd0);
    check("async_rst_ready", 32'(op_ready), 32'd0);
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ready_after_async_rst", 32'(op_ready), 32'd1);
    repeat (6) @(negedge clk);
    for (int ch = 0; ch < C; ch++) send(2'b11, 2'(ch), 8'h00, 1'b1, 8'h00, 1'b0, st);
    op_valid = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
